// File: rtl/shift_pkg.sv
// Shared definitions for the shift unit: operation codes and FSM state encoding.
package shift_pkg;

  localparam logic [2:0] MODE_LOAD   = 3'b000;
  localparam logic [2:0] MODE_LSR    = 3'b001;
  localparam logic [2:0] MODE_LSL    = 3'b010;
  localparam logic [2:0] MODE_ASR    = 3'b011;
  localparam logic [2:0] MODE_ROR    = 3'b100;
  localparam logic [2:0] MODE_ROL    = 3'b101;
  localparam logic [2:0] MODE_SERIAL = 3'b110;
  localparam logic [2:0] MODE_CLEAR  = 3'b111;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // True for the single-cycle modes that go through the barrel shifter.
  function automatic logic is_shift_op(input logic [2:0] mode);
    return (mode >= MODE_LSR) && (mode <= MODE_ROL);
  endfunction

endpackage

// File: rtl/shift_unit_barrel_shifter.sv
// Purely combinational barrel shifter: logical/arithmetic shifts and rotates.
module barrel_shifter
  import shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  data,
  input  logic [SW-1:0] shamt,
  input  logic [2:0]    op,
  output logic [N-1:0]  result
);

  logic [31:0]    rot_amt;
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] ror_w;
  logic [2*N-1:0] rol_w;

  // Rotates work on a doubled word so that any amount mod N is a plain shift;
  // shifts rely on >=N amounts naturally producing zero / full sign fill.
  always_comb begin
    rot_amt = 32'(shamt) % 32'(N);
    dbl     = {data, data};
    ror_w   = dbl >> rot_amt;
    rol_w   = dbl << rot_amt;
    case (op)
      MODE_LSR: result = data >> shamt;
      MODE_LSL: result = data << shamt;
      MODE_ASR: result = $signed(data) >>> shamt;
      MODE_ROR: result = ror_w[N-1:0];
      MODE_ROL: result = rol_w[2*N-1:N];
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Shift unit: parallel load/shift/rotate register plus bit-serial transfer engine.
module shift_unit
  import shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [2:0]    mode,
  input  logic [SW-1:0] shamt,
  input  logic          serial_in,
  input  logic [N-1:0]  load_data,
  output logic [N-1:0]  data,
  output logic          serial_out,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:0]    state_q, state_d;
  logic          done_q, done_d;
  logic [N-1:0]  shifted;

  barrel_shifter #(
    .N  (N),
    .SW (SW)
  ) u_barrel (
    .data   (data_q),
    .shamt  (shamt),
    .op     (mode),
    .result (shifted)
  );

  // Next-state logic: single-cycle ops in IDLE, one serial bit per enabled cycle in SHIFT.
  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = 1'b0;
    if (enable) begin
      if (state_q == ST_IDLE) begin
        if (mode == MODE_LOAD) begin
          data_d = load_data;
        end else if (mode == MODE_CLEAR) begin
          data_d = '0;
        end else if (mode == MODE_SERIAL) begin
          cnt_d   = (shamt == '0) ? CW'(N) : CW'(shamt);
          state_d = ST_SHIFT;
        end else if (is_shift_op(mode)) begin
          data_d = shifted;
        end
      end else begin
        data_d = {serial_in, data_q[N-1:1]};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign data       = data_q;
  assign serial_out = data_q[0];
  assign busy       = (state_q == ST_SHIFT);
  assign done       = done_q;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: stimulus queues expected state, a negedge monitor checks it.
module tb_shift_unit;
  import shift_pkg::*;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [2:0]    mode;
  logic [SW-1:0] shamt;
  logic          serial_in;
  logic [N-1:0]  load_data;
  logic [N-1:0]  data;
  logic          serial_out;
  logic          busy;
  logic          done;

  typedef struct {
    int          tag;
    logic [N-1:0] d;
    logic        b;
    logic        dn;
    string       name;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   neg_n  = 0;

  shift_unit #(.N(N), .SW(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .shamt      (shamt),
    .serial_in  (serial_in),
    .load_data  (load_data),
    .data       (data),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then record what the DUT should show after it.
  task automatic tick(input logic [N-1:0] d, input logic b, input logic dn, input string name);
    exp_t e;
    @(posedge clk);
    edge_n++;
    #1;
    e.tag = edge_n; e.d = d; e.b = b; e.dn = dn; e.name = name;
    q.push_back(e);
  endtask

  task automatic op(input logic [2:0] m, input logic [SW-1:0] s, input logic [N-1:0] ld,
                    input logic [N-1:0] exp_d, input string name);
    mode = m; shamt = s; load_data = ld;
    tick(exp_d, 1'b0, 1'b0, name);
  endtask

  // Monitor: compare every queued expectation at the falling edge it belongs to.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      neg_n++;
      while (q.size() > 0 && q[0].tag <= neg_n) begin
        e = q.pop_front();
        tests++;
        if (e.tag != neg_n || data !== e.d || busy !== e.b || done !== e.dn || serial_out !== e.d[0]) begin
          errors++;
          $display("FAIL %s @edge%0d: data=%h busy=%b done=%b sout=%b, expected data=%h busy=%b done=%b sout=%b",
                   e.name, e.tag, data, busy, done, serial_out, e.d, e.b, e.dn, e.d[0]);
        end
      end
    end
  end

  logic [N-1:0] ser_full [8] = '{8'hA5, 8'hD2, 8'hE9, 8'hF4, 8'hFA, 8'hFD, 8'hFE, 8'hFF};

  initial begin
    rst_n = 1'b0; enable = 1'b1; mode = MODE_LOAD; shamt = '0;
    serial_in = 1'b0; load_data = 8'hFF;

    // Reset dominates enable and a pending load
    tick(8'h00, 1'b0, 1'b0, "reset");
    tick(8'h00, 1'b0, 1'b0, "reset2");
    rst_n = 1'b1; enable = 1'b0;
    for (int i = 0; i < 3; i++) tick(8'h00, 1'b0, 1'b0, "hold_after_reset");

    // Single-cycle operations
    enable = 1'b1;
    op(MODE_LOAD,  3'd0, 8'hB4, 8'hB4, "load_b4");
    op(MODE_ASR,   3'd2, 8'h00, 8'hED, "asr2");
    op(MODE_LSR,   3'd3, 8'h00, 8'h1D, "lsr3");
    op(MODE_LSL,   3'd4, 8'h00, 8'hD0, "lsl4");
    op(MODE_ROR,   3'd1, 8'h00, 8'h68, "ror1");
    op(MODE_ROL,   3'd7, 8'h00, 8'h34, "rol7");
    op(MODE_CLEAR, 3'd5, 8'h00, 8'h00, "clear");
    op(MODE_LOAD,  3'd0, 8'h5A, 8'h5A, "load_5a");
    op(MODE_LSL,   3'd0, 8'h00, 8'h5A, "lsl0_unchanged");
    op(MODE_ROR,   3'd4, 8'h00, 8'hA5, "ror4");
    enable = 1'b0;
    op(MODE_LOAD,  3'd0, 8'h33, 8'hA5, "idle_disabled_hold");
    enable = 1'b1;

    // Serial full word, with a load held on the inputs for the whole transfer
    op(MODE_LOAD, 3'd0, 8'hA5, 8'hA5, "load_a5");
    mode = MODE_SERIAL; shamt = 3'd0; serial_in = 1'b1;
    tick(ser_full[0], 1'b1, 1'b0, "ser_full_start");
    mode = MODE_LOAD; load_data = 8'h55;
    for (int i = 1; i < 8; i++) tick(ser_full[i], 1'b1, 1'b0, "ser_full_bit");
    tick(8'hFF, 1'b0, 1'b1, "ser_full_done");
    tick(8'h55, 1'b0, 1'b0, "op_in_done_cycle");

    // Serial partial transfer with a two-cycle stall
    op(MODE_LOAD, 3'd0, 8'h0F, 8'h0F, "load_0f");
    mode = MODE_SERIAL; shamt = 3'd3; serial_in = 1'b0;
    tick(8'h0F, 1'b1, 1'b0, "ser_part_start");
    mode = MODE_LOAD; load_data = 8'hAA;
    tick(8'h07, 1'b1, 1'b0, "ser_part_bit1");
    enable = 1'b0;
    tick(8'h07, 1'b1, 1'b0, "ser_part_stall1");
    tick(8'h07, 1'b1, 1'b0, "ser_part_stall2");
    enable = 1'b1;
    tick(8'h03, 1'b1, 1'b0, "ser_part_bit2");
    tick(8'h01, 1'b0, 1'b1, "ser_part_done");
    enable = 1'b0;
    tick(8'h01, 1'b0, 1'b0, "done_clears_disabled");
    tick(8'h01, 1'b0, 1'b0, "idle_hold");

    // Reset in the middle of a transfer
    enable = 1'b1;
    op(MODE_LOAD, 3'd0, 8'hA5, 8'hA5, "load_a5_again");
    mode = MODE_SERIAL; shamt = 3'd0; serial_in = 1'b0;
    tick(8'hA5, 1'b1, 1'b0, "ser_rst_start");
    mode = MODE_LSR; shamt = 3'd0;
    tick(8'h52, 1'b1, 1'b0, "ser_rst_bit1");
    tick(8'h29, 1'b1, 1'b0, "ser_rst_bit2");
    tick(8'h14, 1'b1, 1'b0, "ser_rst_bit3");
    rst_n = 1'b0;
    tick(8'h00, 1'b0, 1'b0, "ser_rst_abort");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick(8'h00, 1'b0, 1'b0, "no_done_after_abort");

    // Let the monitor drain, bounded
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
